// File: rtl/mpu_load_store_ctrl.sv
// MPU load/store sequencer between the memory stream and the matrix register file.
// Ports: load_en/store_en commands, mem_* stream side, reg_* register-file side, busy.
module mpu_load_store_ctrl #(
  parameter int FP              = 32,
  parameter int M               = 4,
  parameter int N               = 4,
  parameter int MBITS           = $clog2(M),
  parameter int NBITS           = $clog2(N),
  parameter int MATRIX_REG_SIZE = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en,
  input  logic                       store_en,
  input  logic [FP-1:0]              mem_load_element,
  input  logic [MBITS:0]             mem_m_load_size,
  input  logic [NBITS:0]             mem_n_load_size,
  input  logic [MATRIX_REG_SIZE-1:0] mem_load_addr,
  input  logic [MATRIX_REG_SIZE-1:0] mem_store_addr,
  output logic                       mem_load_ack,
  output logic                       mem_load_error,
  output logic                       mem_store_en,
  output logic [FP-1:0]              mem_store_element,
  output logic [MBITS:0]             mem_m_store_size,
  output logic [NBITS:0]             mem_n_store_size,
  output logic                       reg_load_en,
  output logic [MATRIX_REG_SIZE-1:0] reg_load_addr,
  output logic [FP-1:0]              reg_load_element,
  output logic [MBITS:0]             reg_m_load_size,
  output logic [NBITS:0]             reg_n_load_size,
  output logic [MBITS:0]             reg_i_load_loc,
  output logic [NBITS:0]             reg_j_load_loc,
  output logic                       reg_store_en,
  output logic [MATRIX_REG_SIZE-1:0] reg_store_addr,
  input  logic [FP-1:0]              reg_store_element,
  input  logic [MBITS:0]             reg_m_store_size,
  input  logic [NBITS:0]             reg_n_store_size,
  output logic [MBITS:0]             reg_i_store_loc,
  output logic [NBITS:0]             reg_j_store_loc,
  output logic                       busy
);

  localparam int CW = $clog2(M*N) + 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] ST_SIZE  = 3'd2;
  localparam logic [2:0] STORE    = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam logic [NBITS:0] NONE = 1;
  localparam logic [CW-1:0]  CONE = 1;

  logic [2:0]                 state_q, state_d;
  logic [MBITS:0]             ld_m_q, st_m_q, i_q, li_q;
  logic [NBITS:0]             ld_n_q, st_n_q, j_q, lj_q;
  logic [MATRIX_REG_SIZE-1:0] ld_addr_q, st_addr_q;
  logic [CW-1:0]              cnt_q, total;
  logic [FP-1:0]              ld_data_q;
  logic                       ack_q, err_q, wr_q, st_en_q;
  logic                       load_ok, st_empty, last;
  logic [MBITS:0]             m_cur;
  logic [NBITS:0]             n_cur;

  assign load_ok = (mem_m_load_size != '0) &&
                   (mem_n_load_size != '0) &&
                   (int'(mem_m_load_size) <= M) &&
                   (int'(mem_n_load_size) <= N);

  assign st_empty = (reg_m_store_size == '0) ||
                    (reg_n_store_size == '0);

  // One counter pair serves both directions; pick the active dims.
  assign m_cur = (state_q == LOAD) ? ld_m_q : st_m_q;
  assign n_cur = (state_q == LOAD) ? ld_n_q : st_n_q;
  assign total = CW'(m_cur) * CW'(n_cur);
  assign last  = (cnt_q == total - CONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (load_en)       state_d = load_ok ? LOAD : DONE;
        else if (store_en) state_d = ST_SIZE;
      end
      LOAD:     if (last) state_d = DONE;
      ST_SIZE:  state_d = st_empty ? DONE : STORE;
      STORE:    if (last) state_d = ST_DRAIN;
      ST_DRAIN: state_d = DONE;
      DONE:     if (!load_en && !store_en) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ld_m_q    <= '0;
      ld_n_q    <= '0;
      st_m_q    <= '0;
      st_n_q    <= '0;
      i_q       <= '0;
      j_q       <= '0;
      li_q      <= '0;
      lj_q      <= '0;
      ld_addr_q <= '0;
      st_addr_q <= '0;
      cnt_q     <= '0;
      ld_data_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      st_en_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      st_en_q <= (state_q == STORE);
      case (state_q)
        IDLE: begin
          if (load_en) begin
            if (load_ok) begin
              ld_m_q    <= mem_m_load_size;
              ld_n_q    <= mem_n_load_size;
              ld_addr_q <= mem_load_addr;
              i_q       <= '0;
              j_q       <= '0;
              cnt_q     <= '0;
              ack_q     <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (store_en) begin
            st_addr_q <= mem_store_addr;
          end
        end
        LOAD: begin
          // Element accepted this edge is written next cycle.
          wr_q      <= 1'b1;
          ld_data_q <= mem_load_element;
          li_q      <= i_q;
          lj_q      <= j_q;
          if (last) ack_q <= 1'b0;
        end
        ST_SIZE: begin
          st_m_q <= reg_m_store_size;
          st_n_q <= reg_n_store_size;
          i_q    <= '0;
          j_q    <= '0;
          cnt_q  <= '0;
        end
        default: ;
      endcase
      if (state_q == LOAD || state_q == STORE) begin
        cnt_q <= cnt_q + CONE;
        if (j_q == n_cur - NONE) begin
          j_q <= '0;
          i_q <= i_q + 1'b1;
        end else begin
          j_q <= j_q + NONE;
        end
      end
    end
  end

  assign mem_load_ack      = ack_q;
  assign mem_load_error    = err_q;
  assign mem_store_en      = st_en_q;
  assign mem_store_element = st_en_q ? reg_store_element : '0;
  assign mem_m_store_size  = st_m_q;
  assign mem_n_store_size  = st_n_q;
  assign reg_load_en       = wr_q;
  assign reg_load_addr     = ld_addr_q;
  assign reg_load_element  = ld_data_q;
  assign reg_m_load_size   = ld_m_q;
  assign reg_n_load_size   = ld_n_q;
  assign reg_i_load_loc    = li_q;
  assign reg_j_load_loc    = lj_q;
  assign reg_store_en      = (state_q == STORE);
  assign reg_store_addr    = st_addr_q;
  assign reg_i_store_loc   = i_q;
  assign reg_j_store_loc   = j_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_mpu_load_store_ctrl.sv
// Bench for mpu_load_store_ctrl: directed and random loads/stores
// against a flat-array matrix reference and a register-file model.
module tb_mpu_load_store_ctrl;

  logic        clk;
  logic        rst;
  logic        load_en, store_en;
  logic [31:0] mem_load_element;
  logic [2:0]  mem_m_load_size, mem_n_load_size;
  logic [2:0]  mem_load_addr, mem_store_addr;
  logic        mem_load_ack, mem_load_error, mem_store_en;
  logic [31:0] mem_store_element;
  logic [2:0]  mem_m_store_size, mem_n_store_size;
  logic        reg_load_en;
  logic [2:0]  reg_load_addr;
  logic [31:0] reg_load_element;
  logic [2:0]  reg_m_load_size, reg_n_load_size;
  logic [2:0]  reg_i_load_loc, reg_j_load_loc;
  logic        reg_store_en;
  logic [2:0]  reg_store_addr;
  logic [31:0] reg_store_element;
  logic [2:0]  reg_m_store_size, reg_n_store_size;
  logic [2:0]  reg_i_store_loc, reg_j_store_loc;
  logic        busy;

  mpu_load_store_ctrl dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .store_en(store_en),
    .mem_load_element(mem_load_element),
    .mem_m_load_size(mem_m_load_size),
    .mem_n_load_size(mem_n_load_size),
    .mem_load_addr(mem_load_addr),
    .mem_store_addr(mem_store_addr),
    .mem_load_ack(mem_load_ack),
    .mem_load_error(mem_load_error),
    .mem_store_en(mem_store_en),
    .mem_store_element(mem_store_element),
    .mem_m_store_size(mem_m_store_size),
    .mem_n_store_size(mem_n_store_size),
    .reg_load_en(reg_load_en),
    .reg_load_addr(reg_load_addr),
    .reg_load_element(reg_load_element),
    .reg_m_load_size(reg_m_load_size),
    .reg_n_load_size(reg_n_load_size),
    .reg_i_load_loc(reg_i_load_loc),
    .reg_j_load_loc(reg_j_load_loc),
    .reg_store_en(reg_store_en),
    .reg_store_addr(reg_store_addr),
    .reg_store_element(reg_store_element),
    .reg_m_store_size(reg_m_store_size),
    .reg_n_store_size(reg_n_store_size),
    .reg_i_store_loc(reg_i_store_loc),
    .reg_j_store_loc(reg_j_store_loc),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: indexed writes, comb sizes, 1-cycle read.
  logic [31:0] rf [8][8][8];
  logic [2:0]  rf_m [8] = '{default: 3'd0};
  logic [2:0]  rf_n [8] = '{default: 3'd0};
  logic [31:0] rd_q = '0;

  always @(posedge clk) begin
    if (reg_load_en) begin
      rf[reg_load_addr][reg_i_load_loc][reg_j_load_loc] <= reg_load_element;
      rf_m[reg_load_addr] <= reg_m_load_size;
      rf_n[reg_load_addr] <= reg_n_load_size;
    end
    if (reg_store_en)
      rd_q <= rf[reg_store_addr][reg_i_store_loc][reg_j_store_loc];
  end

  assign reg_store_element = rd_q;
  assign reg_m_store_size  = rf_m[reg_store_addr];
  assign reg_n_store_size  = rf_n[reg_store_addr];

  typedef struct packed {
    logic [2:0]  a;
    logic [2:0]  m;
    logic [2:0]  n;
    logic [2:0]  i;
    logic [2:0]  j;
    logic [31:0] d;
  } wr_t;

  // Reference: each register holds m, n and a flat row-major list.
  int unsigned ref_m [8];
  int unsigned ref_n [8];
  logic [31:0] ref_d [8][16];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input int m, input int n, input int a,
                         input bit rnd, input bit both);
    logic [31:0] ex[$];
    wr_t obs[$];
    wr_t w;
    bit ok;
    int ackc, rise, errc, rsc, k;
    bit prev;
    ok = (m > 0) && (n > 0) && (m <= 4) && (n <= 4);
    if (ok)
      for (int q = 0; q < m * n; q++)
        ex.push_back(rnd ? $urandom : 32'(q + 1));
    ackc = 0; rise = 0; errc = 0; rsc = 0; k = 0; prev = 0;
    load_en         = 1'b1;
    store_en        = both;
    mem_m_load_size = 3'(m);
    mem_n_load_size = 3'(n);
    mem_load_addr   = 3'(a);
    mem_store_addr  = 3'(a);
    repeat (m * n + 5) begin
      @(negedge clk);
      if (reg_load_en)
        obs.push_back('{reg_load_addr, reg_m_load_size,
                        reg_n_load_size, reg_i_load_loc,
                        reg_j_load_loc, reg_load_element});
      if (mem_load_error) errc++;
      if (reg_store_en) rsc++;
      if (mem_load_ack) begin
        ackc++;
        if (!prev) rise++;
        mem_load_element = (k < ex.size()) ? ex[k] : 32'h0;
        k++;
      end
      prev = mem_load_ack;
    end
    chk("ld_held_done", 64'(busy), 64'd1);
    load_en  = 1'b0;
    store_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("ld_idle", 64'(busy), 64'd0);
    chk("ld_ack_cycles", 64'(ackc), ok ? 64'(m * n) : 64'd0);
    chk("ld_ack_rises", 64'(rise), ok ? 64'd1 : 64'd0);
    chk("ld_err_pulse", 64'(errc), ok ? 64'd0 : 64'd1);
    chk("ld_no_store", 64'(rsc), 64'd0);
    chk("ld_nwrites", 64'(obs.size()), 64'(ex.size()));
    if (ok) begin
      for (int i = 0; i < m; i++)
        for (int j = 0; j < n; j++) begin
          w = '{3'(a), 3'(m), 3'(n), 3'(i), 3'(j), ex[i * n + j]};
          if (i * n + j < obs.size())
            chk("ld_write", 64'(obs[i * n + j]), 64'(w));
        end
      ref_m[a] = m;
      ref_n[a] = n;
      for (int q = 0; q < m * n; q++) ref_d[a][q] = ex[q];
    end
  endtask

  task automatic do_store(input int a);
    logic [31:0] got[$];
    int rsc, msc, rise, mn;
    bit prev;
    rsc = 0; msc = 0; rise = 0; prev = 0;
    mn = int'(ref_m[a] * ref_n[a]);
    store_en       = 1'b1;
    mem_store_addr = 3'(a);
    repeat (22) begin
      @(negedge clk);
      if (reg_store_en) rsc++;
      if (mem_store_en) begin
        msc++;
        if (!prev) rise++;
        got.push_back(mem_store_element);
      end
      prev = mem_store_en;
    end
    chk("st_held_done", 64'(busy), 64'd1);
    store_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("st_idle", 64'(busy), 64'd0);
    chk("st_reads", 64'(rsc), 64'(mn));
    chk("st_out_cycles", 64'(msc), 64'(mn));
    chk("st_contiguous", 64'(rise), (mn > 0) ? 64'd1 : 64'd0);
    chk("st_sizes", 64'({mem_m_store_size, mem_n_store_size}),
        64'({3'(ref_m[a]), 3'(ref_n[a])}));
    for (int q = 0; q < mn && q < got.size(); q++)
      chk("st_elem", 64'(got[q]), 64'(ref_d[a][q]));
  endtask

  function automatic logic [63:0] ctrl_vec();
    return 64'({mem_load_ack, mem_load_error, mem_store_en,
                mem_m_store_size, mem_n_store_size,
                reg_load_en, reg_load_addr,
                reg_m_load_size, reg_n_load_size,
                reg_i_load_loc, reg_j_load_loc,
                reg_store_en, reg_store_addr,
                reg_i_store_loc, reg_j_store_loc, busy});
  endfunction

  initial begin
    for (int a = 0; a < 8; a++) begin
      ref_m[a] = 0;
      ref_n[a] = 0;
      for (int q = 0; q < 16; q++) ref_d[a][q] = '0;
    end
    rst = 1'b0;
    load_en = 0; store_en = 0;
    mem_load_element = '0;
    mem_m_load_size = '0; mem_n_load_size = '0;
    mem_load_addr = '0; mem_store_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", ctrl_vec(), 64'd0);
    chk("rst_data", {mem_store_element, reg_load_element}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Abort a 4x4 load with reset, then reload the same register.
    load_en = 1; mem_m_load_size = 3'd4; mem_n_load_size = 3'd4;
    mem_load_addr = 3'd5;
    repeat (5) begin
      @(negedge clk);
      mem_load_element = $urandom;
    end
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    load_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_rst_ctrl", ctrl_vec(), 64'd0);
    chk("mid_rst_data", {mem_store_element, reg_load_element}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    do_load(4, 4, 5, 1, 0);
    do_store(5);

    do_load(2, 3, 2, 0, 0);
    do_load(0, 3, 3, 1, 0);
    do_load(2, 5, 3, 1, 0);
    do_load(5, 2, 3, 1, 0);
    do_load(4, 4, 1, 0, 0);
    do_store(1);
    do_store(6);
    do_store(2);

    // Simultaneous enables: the load wins, no store happens.
    do_load(3, 2, 4, 1, 1);
    do_store(4);

    for (int r = 0; r < 10; r++) begin
      do_load($urandom_range(0, 5), $urandom_range(0, 5),
              $urandom_range(0, 7), 1, 1'($urandom_range(0, 1)));
      do_store($urandom_range(0, 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mpu_load_store_ctrl.md
Name: mpu_load_store_ctrl

Overview:
Sequences matrix transfers between the memory-side streaming interface and the MPU matrix register file. On LOAD it validates the dimensions, acknowledges and accepts a row-major element stream, and issues indexed register-file writes. On STORE it fetches the stored matrix dimensions, issues indexed register-file reads, and streams the elements out to memory. It sits between the MPU top-level command interface (load_en/store_en) and the matrix register file.

Parameters:
FP, 32, element width in bits (32 or 64)
M, 4, maximum matrix rows
N, 4, maximum matrix columns
MBITS, $clog2(M), row index width; size ports are MBITS+1 bits
NBITS, $clog2(N), column index width; size ports are NBITS+1 bits
MATRIX_REG_SIZE, 3, register-file address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
load_en  in  1  load request, held until the operation completes
store_en  in  1  store request, held until the operation completes
mem_load_element  in  FP  incoming matrix element
mem_m_load_size  in  MBITS+1  rows of the incoming matrix
mem_n_load_size  in  NBITS+1  columns of the incoming matrix
mem_load_addr  in  MATRIX_REG_SIZE  destination register
mem_store_addr  in  MATRIX_REG_SIZE  source register
mem_load_ack  out  1  high while elements are being accepted
mem_load_error  out  1  one-cycle pulse on an illegal load size
mem_store_en  out  1  mem_store_element valid
mem_store_element  out  FP  outgoing element
mem_m_store_size  out  MBITS+1  rows of the outgoing matrix
mem_n_store_size  out  NBITS+1  columns of the outgoing matrix
reg_load_en  out  1  register-file write strobe
reg_load_addr  out  MATRIX_REG_SIZE  write register
reg_load_element  out  FP  write data
reg_m_load_size / reg_n_load_size  out  MBITS+1 / NBITS+1  dimensions written with the matrix
reg_i_load_loc / reg_j_load_loc  out  MBITS+1 / NBITS+1  write location
reg_store_en  out  1  register-file read strobe
reg_store_addr  out  MATRIX_REG_SIZE  read register
reg_store_element  in  FP  read data, valid 1 cycle after reg_store_en
reg_m_store_size / reg_n_store_size  in  MBITS+1 / NBITS+1  dimensions of the register at reg_store_addr, combinational
reg_i_store_loc / reg_j_store_loc  out  MBITS+1 / NBITS+1  read location
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs, counters and captured sizes/addresses go to 0. Asserting reset mid-operation aborts the transfer; any register-file writes already issued are not undone.
- States: IDLE, LOAD, ST_SIZE, STORE, ST_DRAIN, DONE.
- IDLE:
  - load_en has priority over store_en when both are high.
  - On load_en, sizes are checked. The size is illegal if m=0, n=0, m>M or n>N.
    - Illegal: mem_load_error is pulsed for 1 cycle, then -> DONE.
    - Legal: mem_m/n_load_size and mem_load_addr are captured, i=j=0, -> LOAD.
  - On store_en: mem_store_addr is captured into reg_store_addr, -> ST_SIZE.
- LOAD:
  - mem_load_ack is registered high for exactly m*n cycles.
  - On each clk edge with ack high, mem_load_element is sampled.
  - The next cycle, reg_load_en=1 with that element, current i/j, captured addr and sizes (write latency 1).
  - Order is row-major: j increments; at j=n-1, j wraps to 0 and i increments.
  - After element m*n-1: ack drops, -> DONE. The final reg_load_en occurs in the first DONE cycle.
- ST_SIZE (1 cycle):
  - reg_m/n_store_size are sampled into mem_m/n_store_size.
  - If either is 0 (empty register): -> DONE with no mem_store_en.
  - Otherwise -> STORE.
- STORE:
  - reg_store_en=1 for m*n consecutive cycles, with row-major i/j.
  - mem_store_en is reg_store_en delayed 1 cycle. mem_store_element = reg_store_element.
  - After the last read: -> ST_DRAIN.
- ST_DRAIN: the last mem_store_en cycle, -> DONE. mem_store_en is therefore high for exactly m*n contiguous cycles.
- DONE: waits until both load_en and store_en are low, then -> IDLE. A held enable never retriggers an operation.
- Enable deasserted mid-transfer: ignored; the transfer completes.
- Size arithmetic: m*n is computed in $clog2(M*N)+1 bits. The element counter is the same width.

Test Plan:
- Reset: hold rst=0 for 5 cycles mid-LOAD -> all outputs 0, busy=0, and a fresh load then succeeds.
- Load 2x3 (elements 1..6, addr 2) -> mem_load_ack high for exactly 6 cycles; reg_load_en writes (0,0)=1, (0,1)=2, (0,2)=3, (1,0)=4, (1,1)=5, (1,2)=6 to addr 2 with sizes 2/3; then DONE until load_en=0.
- Illegal loads: m=0, n=5 (N=4), m=M+1 -> mem_load_error pulses exactly 1 cycle, no ack, no reg_load_en.
- Store after 4x4 load (addr 1): register-file model returns data 1 cycle later -> mem_store_en high for 16 contiguous cycles, elements in row-major order, mem_m/n_store_size = 4/4.
- Store from an empty register (sizes 0) -> no reg_store_en, no mem_store_en, busy drops after load/store enables clear.
- load_en and store_en asserted in the same cycle -> the load executes first; the store starts only after both enables drop and store_en is raised again.
